// File: rtl/rect_raster_if.sv
// Rectangle rasteriser request/pixel bundle.
// Hole ports exist only when RECT_RASTER_HOLE_EN is defined.
interface rect_raster_if;
  logic       start;
  logic [7:0] start_x;
  logic [6:0] start_y;
  logic [7:0] width;
  logic [6:0] height;
  logic [2:0] colour_in;
`ifdef RECT_RASTER_HOLE_EN
  logic [6:0] hole_y;
  logic [6:0] hole_h;
`endif
  logic       busy;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       finished_draw;

`ifdef RECT_RASTER_HOLE_EN
  modport master (
    output start, start_x, start_y,
    output width, height, colour_in,
    output hole_y, hole_h,
    input  busy, x_out, y_out,
    input  colour_out, plot, finished_draw
  );
  modport slave (
    input  start, start_x, start_y,
    input  width, height, colour_in,
    input  hole_y, hole_h,
    output busy, x_out, y_out,
    output colour_out, plot, finished_draw
  );
`else
  modport master (
    output start, start_x, start_y,
    output width, height, colour_in,
    input  busy, x_out, y_out,
    input  colour_out, plot, finished_draw
  );
  modport slave (
    input  start, start_x, start_y,
    input  width, height, colour_in,
    output busy, x_out, y_out,
    output colour_out, plot, finished_draw
  );
`endif
endinterface

// File: rtl/rect_raster.sv
// Row-major rectangle rasteriser, one pixel per clock, with clipping.
// RECT_RASTER_HOLE_EN adds a background-coloured band of hole rows.
module rect_raster #(
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'b111
) (
  input logic          clk,
  input logic          reset,
  rect_raster_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] c;
`ifdef RECT_RASTER_HOLE_EN
    logic [6:0] hy;
    logic [6:0] hh;
`endif
  } rect_t;

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

  state_t     state, state_n;
  rect_t      rect, rect_n;
  logic [7:0] col, col_n;
  logic [6:0] row, row_n;

  logic       busy_q, busy_n;
  logic       plot_q, plot_n;
  logic       fin_q, fin_n;
  logic [7:0] x_q, x_n;
  logic [6:0] y_q, y_n;
  logic [2:0] c_q, c_n;

  logic       last_col;
  logic       last_row;
  logic       draw_n;
  logic       in_hole;
  logic [8:0] px;
  logic [7:0] py;
`ifdef RECT_RASTER_HOLE_EN
  logic [7:0] hole_lo;
  logic [7:0] hole_hi;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rect   <= '0;
      col    <= '0;
      row    <= '0;
      busy_q <= 1'b0;
      plot_q <= 1'b0;
      fin_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= '0;
    end else begin
      state  <= state_n;
      rect   <= rect_n;
      col    <= col_n;
      row    <= row_n;
      busy_q <= busy_n;
      plot_q <= plot_n;
      fin_q  <= fin_n;
      x_q    <= x_n;
      y_q    <= y_n;
      c_q    <= c_n;
    end
  end

  assign last_col = (col == rect.w - 8'd1);
  assign last_row = (row == rect.h - 7'd1);

  always_comb begin
    state_n = state;
    rect_n  = rect;
    col_n   = col;
    row_n   = row;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          rect_n.x  = bus.start_x;
          rect_n.y  = bus.start_y;
          rect_n.w  = bus.width;
          rect_n.h  = bus.height;
          rect_n.c  = bus.colour_in;
`ifdef RECT_RASTER_HOLE_EN
          rect_n.hy = bus.hole_y;
          rect_n.hh = bus.hole_h;
`endif
          col_n = '0;
          row_n = '0;
          if (bus.width == 8'd0 ||
              bus.height == 7'd0)
            state_n = DONE;
          else
            state_n = DRAW;
        end
      end
      DRAW: begin
        unique case (1'b1)
          last_col && last_row: begin
            col_n   = '0;
            state_n = DONE;
          end
          last_col && !last_row: begin
            col_n = '0;
            row_n = row + 7'd1;
          end
          default: col_n = col + 8'd1;
        endcase
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from next-cycle state.
  always_comb begin
    px     = {1'b0, rect_n.x} + {1'b0, col_n};
    py     = {1'b0, rect_n.y} + {1'b0, row_n};
    draw_n = (state_n == DRAW);
`ifdef RECT_RASTER_HOLE_EN
    hole_lo = {1'b0, rect_n.hy};
    hole_hi = {1'b0, rect_n.hy}
            + {1'b0, rect_n.hh};
    in_hole = (py >= hole_lo) &&
              (py < hole_hi);
`else
    in_hole = 1'b0;
`endif
    busy_n = draw_n;
    fin_n  = (state_n == DONE);
    plot_n = draw_n && (px < X_LIM) &&
             (py < Y_LIM);
    x_n    = x_q;
    y_n    = y_q;
    c_n    = c_q;
    if (draw_n) begin
      x_n = px[7:0];
      y_n = py[6:0];
      c_n = in_hole ? BG_COLOUR : rect_n.c;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.plot          = plot_q;
  assign bus.finished_draw = fin_q;
  assign bus.x_out         = x_q;
  assign bus.y_out         = y_q;
  assign bus.colour_out    = c_q;

endmodule

// File: tb/tb_rect_raster.sv
// Directed bench for rect_raster: reset, basic, zero size,
// clipping, busy-ignore, abort and optional hole rows.
module tb_rect_raster;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  rect_raster_if bus ();

  rect_raster dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag,
                          input logic fin);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".plot"}, 32'(bus.plot), 0);
    chk({tag, ".fin"},
        32'(bus.finished_draw), 32'(fin));
  endtask

  task automatic set_in(input int sx, sy, w, h,
                        input logic [2:0] c,
                        input int hy, hh);
    bus.start_x   = 8'(sx);
    bus.start_y   = 7'(sy);
    bus.width     = 8'(w);
    bus.height    = 7'(h);
    bus.colour_in = c;
`ifdef RECT_RASTER_HOLE_EN
    bus.hole_y    = 7'(hy);
    bus.hole_h    = 7'(hh);
`endif
    if (hy < 0 || hh < 0) $display("bad hole");
  endtask

  task automatic start_draw(input int sx, sy, w, h,
                            input logic [2:0] c,
                            input int hy, hh);
    set_in(sx, sy, w, h, c, hy, hh);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Walks the whole rectangle; pixel 0 is on the outputs at entry.
  task automatic check_rect(input string tag,
                            input int sx, sy, w, h,
                            input logic [2:0] c,
                            input int hy, hh,
                            input int nplot_exp);
    int np;
    int px;
    int py;
    logic pe;
    logic [2:0] ce;
    np = 0;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        px = sx + k;
        py = sy + r;
        pe = (px < 160) && (py < 120);
        ce = c;
        if (hh > 0 && py >= hy && py < hy + hh)
          ce = 3'b111;
        chk({tag, ".plot"}, 32'(bus.plot), 32'(pe));
        chk({tag, ".x"}, 32'(bus.x_out), px % 256);
        chk({tag, ".y"}, 32'(bus.y_out), py % 128);
        chk({tag, ".col"},
            32'(bus.colour_out), 32'(ce));
        chk({tag, ".busy"}, 32'(bus.busy), 1);
        chk({tag, ".fin0"},
            32'(bus.finished_draw), 0);
        if (bus.plot) np++;
        step();
      end
    end
    chk_idle({tag, ".done"}, 1'b1);
    chk({tag, ".nplot"}, 32'(np), 32'(nplot_exp));
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    set_in(0, 0, 0, 0, 3'b000, 0, 0);
    step();
    step();
    chk_idle("rst", 1'b0);
    chk("rst.x", 32'(bus.x_out), 0);
    chk("rst.y", 32'(bus.y_out), 0);
    chk("rst.c", 32'(bus.colour_out), 0);
    reset = 1'b0;
    step();
    chk_idle("idle", 1'b0);

    // Basic, with a re-pulsed start and input changes while busy
    set_in(10, 5, 3, 2, 3'b100, 0, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("basic.p0x", 32'(bus.x_out), 10);
    chk("basic.p0y", 32'(bus.y_out), 5);
    chk("basic.p0plot", 32'(bus.plot), 1);
    fork
      check_rect("basic", 10, 5, 3, 2,
                 3'b100, 0, 0, 6);
      begin
        step();
        set_in(50, 60, 9, 9, 3'b010, 0, 0);
        bus.start = 1'b1;
        step();
        step();
        bus.start = 1'b0;
      end
    join
    // start held during DONE must be ignored
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_idle("done_ign", 1'b0);
    step();
    chk_idle("done_ign2", 1'b0);

    // Zero width: straight to DONE
    start_draw(7, 7, 0, 20, 3'b001, 0, 0);
    chk_idle("zero", 1'b1);
    step();
    chk_idle("zero.end", 1'b0);
    start_draw(7, 7, 5, 0, 3'b001, 0, 0);
    chk_idle("zeroh", 1'b1);
    step();

    // Clipping at the bottom-right corner
    start_draw(158, 119, 4, 2, 3'b010, 0, 0);
    check_rect("clip", 158, 119, 4, 2,
               3'b010, 0, 0, 2);
    step();

    // Abort while the 3rd pixel is shown
    start_draw(20, 30, 5, 2, 3'b110, 0, 0);
    chk("abort.p0x", 32'(bus.x_out), 20);
    step();
    step();
    chk("abort.p2x", 32'(bus.x_out), 22);
    chk("abort.p2plot", 32'(bus.plot), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("abort", 1'b0);
    chk("abort.x", 32'(bus.x_out), 0);
    chk("abort.c", 32'(bus.colour_out), 0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort.nofin",
          32'(bus.finished_draw), 0);
    end
    start_draw(1, 2, 2, 2, 3'b001, 0, 0);
    check_rect("post", 1, 2, 2, 2,
               3'b001, 0, 0, 4);
    step();

`ifdef RECT_RASTER_HOLE_EN
    start_draw(100, 0, 2, 8, 3'b100, 3, 2);
    chk("hole.r0c", 32'(bus.colour_out), 4);
    check_rect("hole", 100, 0, 2, 8,
               3'b100, 3, 2, 16);
    step();
    start_draw(5, 5, 1, 2, 3'b011, 5, 0);
    check_rect("hole0", 5, 5, 1, 2,
               3'b011, 5, 0, 2);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
